// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared types and helpers for the sequential priority encoder.
//   state_t      : FSM states of prio_encoder_seq (IDLE, EMIT)
//   MODE_SINGLE  : in_mode value for a single priority encode with multi-bit flag
//   MODE_DRAIN   : in_mode value for emitting every set bit, one beat per bit
//   idx_width()  : ceil(log2(width)), the width of an encoded index
package prio_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_DRAIN  = 1'b1;

  // Written as a plain loop so it folds to a constant during elaboration
  // and can size ports in a parameter list.
  function automatic int idx_width(input int width);
    int w;
    w = 0;
    for (int i = 0; i < 16; i++) begin
      if ((1 << i) < width) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational priority selector.
//   Parameters : WIDTH (input lines), MSB_FIRST (0 = lowest index wins,
//                1 = highest index wins)
//   vec           in  WIDTH  candidate bits
//   idx           out IDX_W  index of the winning bit (0 when vec is zero)
//   any           out 1      at least one bit set
//   multi         out 1      more than one bit set
//   onehot_of_idx out WIDTH  one-hot mask of the winning bit (all zero when none)
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi,
  output logic [WIDTH-1:0] onehot_of_idx
);

  // w_ord is vec reordered so that position 0 always has the highest
  // priority; this keeps the chain below identical for both directions.
  logic [WIDTH-1:0] w_ord;
  logic [WIDTH-1:0] w_seen;     // w_seen[k]: a higher-priority bit than k is set
  logic [WIDTH-1:0] w_sel_ord;  // winner, in priority order
  logic [WIDTH-1:0] w_dup;      // set bits that lost to a higher-priority one

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_order
      localparam int SRC = MSB_FIRST ? (WIDTH - 1 - gi) : gi;
      assign w_ord[gi]          = vec[SRC];
      assign w_sel_ord[gi]      = w_ord[gi] & ~w_seen[gi];
      assign w_dup[gi]          = w_ord[gi] & w_seen[gi];
      assign onehot_of_idx[SRC] = w_sel_ord[gi];
    end
  endgenerate

  // Prefix-OR built with a local accumulator to avoid a self-referencing vector.
  always_comb begin
    logic v_acc;
    v_acc  = 1'b0;
    w_seen = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_seen[k] = v_acc;
      v_acc     = v_acc | w_ord[k];
    end
    any = v_acc;
  end

  assign multi = |w_dup;

  // The mask is one-hot (or zero), so OR-ing the indices of set mask bits
  // yields the winner's index without a priority mux.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_of_idx[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/prio_encoder_seq.sv
// prio_encoder_seq: registered priority encoder with valid/ready on both sides.
//   Parameters : WIDTH (2..256), MSB_FIRST (priority direction)
//   clk, rst   in   clock, synchronous active-high reset
//   in_valid   in   in_vec / in_mode valid
//   in_ready   out  block idle and able to take a vector
//   in_vec     in   WIDTH request vector
//   in_mode    in   MODE_SINGLE or MODE_DRAIN
//   out_valid  out  out_* beat valid
//   out_ready  in   consumer takes the current beat
//   out_idx    out  encoded index of the selected bit
//   out_last   out  final beat of this vector
//   out_err    out  single-shot vector had more than one bit set
//   out_zero   out  vector was all zeros
// Single-shot produces one beat per vector; drain produces one beat per set
// bit in priority order. All out_* fields come straight from flops.
module prio_encoder_seq
  import prio_enc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_err,
  output logic             out_zero
);

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_pend;      // bits of the captured vector not yet retired
  logic [WIDTH-1:0] w_pend_next;
  logic             r_mode;
  logic             w_mode_next;
  logic [WIDTH-1:0] r_onehot;    // mask of the bit currently on out_idx

  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;
  logic             r_err;
  logic             r_zero;

  logic             w_accept;
  logic             w_take;
  logic             w_advance;
  logic             w_load;

  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_multi;
  logic [WIDTH-1:0] w_onehot;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_take    = r_valid && out_ready;
  assign w_advance = w_take && !r_last;
  // A new beat is loaded either from a fresh vector or from the remainder of
  // a drain; both happen in the same cycle as the handshake that triggers
  // them, which gives 1-cycle latency and back-to-back drain beats.
  assign w_load    = w_accept || w_advance;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = EMIT;
      EMIT:    if (w_take && r_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- pending vector ----------------
  always_comb begin
    w_pend_next = r_pend;
    w_mode_next = r_mode;
    if (w_accept) begin
      w_pend_next = in_vec;
      w_mode_next = in_mode;
    end else if (w_advance) begin
      w_pend_next = r_pend & ~r_onehot;
    end
  end

  // The picker looks at the value the pending register is about to take, so
  // the beat it describes can be registered in the same edge.
  prio_pick #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_pick (
    .vec           (w_pend_next),
    .idx           (w_idx),
    .any           (w_any),
    .multi         (w_multi),
    .onehot_of_idx (w_onehot)
  );

  // ---------------- capture and output registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= '0;
      r_mode   <= MODE_SINGLE;
      r_onehot <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      r_mode <= w_mode_next;
      if (w_load) begin
        r_valid  <= 1'b1;
        r_idx    <= w_idx;
        r_onehot <= w_onehot;
        // Drain: last when only one bit is left (or none, for a zero vector).
        r_last   <= (w_mode_next == MODE_SINGLE) || !w_multi;
        r_err    <= (w_mode_next == MODE_SINGLE) && w_multi;
        r_zero   <= !w_any;
      end else if (w_take) begin
        // Final beat consumed: return the outputs to their quiet values.
        r_valid  <= 1'b0;
        r_idx    <= '0;
        r_onehot <= '0;
        r_last   <= 1'b0;
        r_err    <= 1'b0;
        r_zero   <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign out_err   = r_err;
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_prio_encoder_seq.sv
`timescale 1ns/1ps
module tb_prio_encoder_seq;

  localparam int ND = 3;  // 0: W8 LSB-first, 1: W8 MSB-first, 2: W5 LSB-first

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tv;
  logic       tm;
  logic       o_rdy;
  bit         rand_rdy;

  logic       iv [ND];
  logic       ir [ND];
  logic       ov [ND];
  logic [2:0] oi [ND];
  logic       ol [ND];
  logic       oe [ND];
  logic       oz [ND];

  int n_chk = 0;
  int n_bad = 0;
  int busy [ND];
  int n_txn = 0;

  prio_encoder_seq #(.WIDTH(8), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_vec(tv),
    .in_mode(tm), .out_valid(ov[0]), .out_ready(o_rdy), .out_idx(oi[0]),
    .out_last(ol[0]), .out_err(oe[0]), .out_zero(oz[0]));

  prio_encoder_seq #(.WIDTH(8), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_vec(tv),
    .in_mode(tm), .out_valid(ov[1]), .out_ready(o_rdy), .out_idx(oi[1]),
    .out_last(ol[1]), .out_err(oe[1]), .out_zero(oz[1]));

  prio_encoder_seq #(.WIDTH(5), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_vec(tv[4:0]),
    .in_mode(tm), .out_valid(ov[2]), .out_ready(o_rdy), .out_idx(oi[2]),
    .out_last(ol[2]), .out_err(oe[2]), .out_zero(oz[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected beats encoded as {idx[2:0], last, err, zero}.
  logic [5:0] q0 [$];
  logic [5:0] q1 [$];
  logic [5:0] q2 [$];

  function automatic int dwidth(input int d);
    return (d == 2) ? 5 : 8;
  endfunction

  task automatic push_exp(input int d, input logic [5:0] b);
    case (d)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop_exp(input int d, output logic [5:0] b);
    case (d)
      0: b = q0.pop_front();
      1: b = q1.pop_front();
      default: b = q2.pop_front();
    endcase
  endtask

  // Lists the set bits in priority order, then turns the list into beats.
  task automatic model(input int d, input logic [7:0] v, input logic m);
    int w;
    int set[$];
    int n;
    w = dwidth(d);
    for (int j = 0; j < w; j++) begin
      int i;
      i = (d == 1) ? (w - 1 - j) : j;
      if (v[i]) set.push_back(i);
    end
    n = set.size();
    if (n == 0) begin
      push_exp(d, {3'd0, 1'b1, 1'b0, 1'b1});
    end else if (!m) begin
      push_exp(d, {3'(set[0]), 1'b1, (n > 1), 1'b0});
    end else begin
      for (int k = 0; k < n; k++) push_exp(d, {3'(set[k]), (k == n - 1), 1'b0, 1'b0});
    end
  endtask

  // ---------------- output monitor ----------------
  logic [6:0] held [ND];
  bit         stalled [ND];

  initial begin
    for (int d = 0; d < ND; d++) stalled[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (rst) begin
          stalled[d] = 1'b0;
          case (d)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
          endcase
        end else begin
          logic [6:0] cur;
          logic [5:0] exp_b;
          cur = {ov[d], oi[d], ol[d], oe[d], oz[d]};
          if (stalled[d]) check_eq($sformatf("d%0d_hold", d), 32'(cur), 32'(held[d]));
          if (ov[d]) begin
            check_eq($sformatf("d%0d_rdy_busy", d), 32'(ir[d]), 32'd0);
            check_eq($sformatf("d%0d_idx_rng", d), 32'(int'(oi[d]) < dwidth(d)), 32'd1);
            if (o_rdy) begin
              if (qsize(d) == 0) begin
                check_eq($sformatf("d%0d_extra_beat", d), 32'(ov[d]), 32'd0);
              end else begin
                pop_exp(d, exp_b);
                check_eq($sformatf("d%0d_beat", d), 32'(cur[5:0]), 32'(exp_b));
              end
            end
          end
          stalled[d] = ov[d] && !o_rdy;
          held[d]    = cur;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) o_rdy = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver ----------------
  task automatic run_txn(input logic [7:0] v, input logic m, input bit wait_done);
    int cyc;
    int acc_at[ND];
    bit acc[ND];
    bit lat[ND];
    bit done[ND];
    bit fin;
    bit all_acc;
    cyc = 0;
    fin = 1'b0;
    for (int d = 0; d < ND; d++) begin
      acc[d] = 1'b0; lat[d] = 1'b0; done[d] = 1'b0; iv[d] = 1'b1; acc_at[d] = 0;
    end
    tv = v;
    tm = m;
    while (!fin && cyc < 300) begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < ND; d++) begin
        if (lat[d]) begin
          check_eq($sformatf("d%0d_latency", d), 32'(ov[d]), 32'd1);
          lat[d] = 1'b0;
        end
        if (acc[d] && !done[d] && ir[d]) begin
          done[d] = 1'b1;
          busy[d] = cyc - acc_at[d];
        end
        if (iv[d] && ir[d]) begin
          acc[d] = 1'b1; acc_at[d] = cyc; lat[d] = 1'b1;
          model(d, v, m);
        end
      end
      fin = 1'b1;
      all_acc = 1'b1;
      for (int d = 0; d < ND; d++) begin
        if (wait_done ? !done[d] : (!acc[d] || lat[d])) fin = 1'b0;
        if (!acc[d]) all_acc = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) if (acc[d]) iv[d] = 1'b0;
      // Captured vectors must be immune to later in_vec activity.
      if (all_acc) tv = 8'($urandom);
    end
    check_eq("txn_complete", 32'(fin), 32'd1);
    n_txn++;
    $display("txn %0d vec=%02h mode=%0d busy=%0d/%0d/%0d", n_txn, v, m, busy[0], busy[1], busy[2]);
  endtask

  task automatic wait_idle();
    int cyc;
    bit idle;
    cyc = 0;
    idle = 1'b0;
    while (!idle && cyc < 100) begin
      @(negedge clk);
      cyc++;
      idle = 1'b1;
      for (int d = 0; d < ND; d++) if (ov[d] || !ir[d]) idle = 1'b0;
      @(posedge clk);
      #1;
    end
    check_eq("idle_reached", 32'(idle), 32'd1);
  endtask

  initial begin
    rst = 1'b1; tv = '0; tm = 1'b0; o_rdy = 1'b1; rand_rdy = 1'b0;
    for (int d = 0; d < ND; d++) begin iv[d] = 1'b0; busy[d] = 0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("d%0d_rst_ready", d), 32'(ir[d]), 32'd0);
      check_eq($sformatf("d%0d_rst_out", d), 32'({ov[d], oi[d], ol[d], oe[d], oz[d]}), 32'd0);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_eq($sformatf("d%0d_ready_after_rst", d), 32'(ir[d]), 32'd1);
    @(posedge clk); #1;

    // Single-shot one-hot, then multi-bit single-shot, then drain.
    run_txn(8'b0010_0000, 1'b0, 1'b1);
    check_eq("single_busy", 32'(busy[0]), 32'd2);
    run_txn(8'b1001_0100, 1'b0, 1'b1);
    run_txn(8'b1001_0100, 1'b1, 1'b1);
    check_eq("drain_busy", 32'(busy[0]), 32'd4);
    check_eq("drain_busy_w5", 32'(busy[2]), 32'd3);

    // First drain beat stalled for three edges.
    o_rdy = 1'b0;
    run_txn(8'b0000_0110, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1; o_rdy = 1'b1;
    wait_idle();

    // Zero vector in both modes.
    run_txn(8'h00, 1'b0, 1'b1);
    check_eq("zero_single_busy", 32'(busy[0]), 32'd2);
    run_txn(8'h00, 1'b1, 1'b1);
    check_eq("zero_drain_busy", 32'(busy[0]), 32'd2);

    // Reset in the middle of a drain after three beats.
    run_txn(8'hFF, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_eq($sformatf("d%0d_ready_in_rst", d), 32'(ir[d]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      check_eq($sformatf("d%0d_flush_out", d), 32'({ov[d], oi[d], ol[d], oe[d], oz[d]}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_eq($sformatf("d%0d_ready_post", d), 32'(ir[d]), 32'd1);
    @(posedge clk); #1;
    run_txn(8'h01, 1'b0, 1'b1);

    // Two-bit drain that exercises the top index of the 5-bit instance.
    run_txn(8'h11, 1'b1, 1'b1);

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int t = 0; t < 60; t++) begin
      logic [7:0] v;
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0)      v = 8'h00;
      else if (kind == 1) v = 8'(1 << $urandom_range(0, 7));
      else                v = 8'($urandom);
      run_txn(v, 1'($urandom_range(0, 1)), 1'b1);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2; o_rdy = 1'b1;
    wait_idle();
    check_eq("leftover_beats", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/prio_encoder_seq.md
Name: prio_encoder_seq

Overview:
- Parametrised, registered successor to the team's fixed 4-to-2 encoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake and produces encoded index beats over a second valid/ready handshake.
- Two modes:
  - Single-shot priority encode, which flags a non-one-hot input.
  - Drain, which emits the index of every set bit, one beat per bit, in priority order.
- Sits between request/interrupt collectors and downstream consumers that need one index at a time.

Parameters:
- WIDTH, 8, number of input lines; legal range 2..256.
- MSB_FIRST, 0, priority direction: 0 = lowest set index wins, 1 = highest set index wins.
- IDX_W, derived as clog2(WIDTH); localparam, not user-overridable.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_vec and in_mode are valid.
- in_ready  out  1  block can accept a vector.
- in_vec  in  WIDTH  request vector.
- in_mode  in  1  0 = single-shot, 1 = drain.
- out_valid  out  1  out_* fields are valid.
- out_ready  in  1  consumer accepts the current beat.
- out_idx  out  IDX_W  encoded index of the selected bit.
- out_last  out  1  final beat for this vector.
- out_err  out  1  single-shot only: more than one bit was set.
- out_zero  out  1  the vector was all zeros.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset:
  - state = IDLE; out_valid, out_idx, out_last, out_err and out_zero = 0.
  - in_ready = 0 while rst is high.
  - A vector in flight is discarded, with no partial beats after reset.
- FSM states: IDLE, EMIT.
- in_ready = (state == IDLE) && !rst. Input is accepted when in_valid && in_ready.
- IDLE, on accept:
  - Capture in_vec into the pending register and in_mode into the mode register.
  - Go to EMIT.
  - out_valid rises on the next cycle, so there is 1 cycle of latency from accept to the first beat.
- Beat contents are computed from the pending register:
  - Zero vector, either mode: one beat with out_idx = 0, out_zero = 1, out_last = 1, out_err = 0.
  - Single-shot: one beat with out_idx = the priority bit, out_err = (popcount > 1), out_last = 1.
  - Drain: out_idx = the priority bit of the pending register; out_last = 1 when exactly one bit remains; out_err = 0.
- EMIT, while out_valid && !out_ready:
  - All out_* fields and the pending register hold stable.
  - No field may change while stalled.
- EMIT, on out_valid && out_ready:
  - If the beat was last, go to IDLE and deassert out_valid on the next cycle.
  - Otherwise (drain), clear the emitted bit in the pending register and present the next beat on the next cycle with out_valid held high. This gives back-to-back beats at full throughput.
- Throughput:
  - Single-shot: 1 vector per 2 cycles with out_ready tied high.
  - Drain: popcount + 1 cycles per vector.
- Priority direction is fixed by MSB_FIRST, and the same direction applies in both modes.
- in_vec changes while in EMIT are ignored, because only the captured vector is used.
- If rst and an output handshake occur in the same cycle, rst wins.
- WIDTH that is not a power of two:
  - Unused high index codes are never produced.
  - IDX_W still equals clog2(WIDTH).
- out_idx is driven straight from a flop, with no combinational path from in_* to out_*.

Decomposition:
- Package prio_enc_pkg:
  - State enum {IDLE, EMIT}.
  - Mode constants MODE_SINGLE = 1'b0, MODE_DRAIN = 1'b1.
  - An idx-width helper function (clog2).
- Sub-module prio_pick (combinational, parameters WIDTH and MSB_FIRST):
  - Inputs: vec.
  - Outputs: idx, any, multi (popcount > 1), onehot_of_idx (mask used to clear the bit).
  - Instantiated once on the pending register.
- The top level holds the FSM, the capture registers and the output registers.

Test Plan:
- WIDTH=8, MSB_FIRST=0, single-shot, in_vec=8'b0010_0000, out_ready=1 -> one beat 1 cycle after accept: idx=5, last=1, err=0, zero=0; in_ready returns high 2 cycles after accept.
- Single-shot, in_vec=8'b1001_0100 -> idx=2, err=1, last=1. Same stimulus with MSB_FIRST=1 -> idx=7, err=1.
- Drain, in_vec=8'b1001_0100, out_ready=1 -> consecutive beats idx=2,4,7 with last=0,0,1, out_valid continuous; in_ready is low throughout.
- Drain, in_vec=8'b0000_0110, out_ready low for 3 cycles on the first beat -> idx=1 is held stable for all 3 cycles, then idx=2 with last=1; no beat is lost or duplicated.
- in_vec=0 in each mode -> single beat: idx=0, zero=1, last=1, err=0.
- Drain, in_vec=8'hFF, rst asserted after the 3rd beat -> on the next cycle out_valid=0 and all outputs are 0; after rst falls, in_ready=1 and a new single-shot vector 8'h01 gives idx=0 with no stale beats.
- Parametric repeat with WIDTH=5 and drain of 5'b10001 -> idx=0,4; IDX_W=3; no idx > 4 is ever produced.
